// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// hazard or branch flush, and a saturating count of hazard bubbles.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              id_RegDst,
    input  logic              id_RegWrite,
    input  logic              id_ALUSrc,
    input  logic              id_MemWrite,
    input  logic              id_MemRead,
    input  logic              id_MemToReg,
    input  logic              id_Branch,
    input  logic [2:0]        id_ALUOp,
    input  logic [1:0]        id_load_mode,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [5:0]        id_funct,
    output logic              ex_valid,
    output logic              ex_RegDst,
    output logic              ex_RegWrite,
    output logic              ex_ALUSrc,
    output logic              ex_MemWrite,
    output logic              ex_MemRead,
    output logic              ex_MemToReg,
    output logic              ex_Branch,
    output logic [2:0]        ex_ALUOp,
    output logic [1:0]        ex_load_mode,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [5:0]        ex_funct,
    output logic [REG_W-1:0]  ex_write_reg,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_count
);

    typedef struct packed {
        logic              valid;
        logic              reg_dst;
        logic              reg_write;
        logic              alu_src;
        logic              mem_write;
        logic              mem_read;
        logic              mem_to_reg;
        logic              branch;
        logic [2:0]        alu_op;
        logic [1:0]        load_mode;
        logic [DATA_W-1:0] pc_plus4;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [5:0]        funct;
        logic [REG_W-1:0]  write_reg;
    } ex_t;

    ex_t              ex_d, ex_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             uses_rt;
    logic             hazard_raw;

    // A bubble is a harmless no-op; MemToReg=1 matches the decoder's idle word.
    function automatic ex_t bubble();
        ex_t b;
        b            = '0;
        b.mem_to_reg = 1'b1;
        return b;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        uses_rt    = ~id_ALUSrc | id_MemWrite;
        hazard_raw = ex_q.valid & ex_q.mem_read & (ex_q.write_reg != '0) & id_valid &
                     ((ex_q.write_reg == id_rs) | (uses_rt & (ex_q.write_reg == id_rt)));
        hazard_stall = hazard_raw & ~flush;

        cnt_d = cnt_q;
        ex_d  = bubble();
        if (flush) begin
            ex_d = bubble();
        end else if (hazard_raw) begin
            ex_d  = bubble();
            cnt_d = sat_inc(cnt_q);
        end else begin
            ex_d.valid      = id_valid;
            ex_d.reg_dst    = id_RegDst;
            ex_d.reg_write  = id_RegWrite;
            ex_d.alu_src    = id_ALUSrc;
            ex_d.mem_write  = id_MemWrite;
            ex_d.mem_read   = id_MemRead;
            ex_d.mem_to_reg = id_MemToReg;
            ex_d.branch     = id_Branch;
            ex_d.alu_op     = id_ALUOp;
            ex_d.load_mode  = id_load_mode;
            ex_d.pc_plus4   = id_pc_plus4;
            ex_d.rs_data    = id_rs_data;
            ex_d.rt_data    = id_rt_data;
            ex_d.imm        = id_imm;
            ex_d.rs         = id_rs;
            ex_d.rt         = id_rt;
            ex_d.rd         = id_rd;
            ex_d.funct      = id_funct;
            ex_d.write_reg  = id_RegDst ? id_rd : id_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= bubble();
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_RegDst    = ex_q.reg_dst;
    assign ex_RegWrite  = ex_q.reg_write;
    assign ex_ALUSrc    = ex_q.alu_src;
    assign ex_MemWrite  = ex_q.mem_write;
    assign ex_MemRead   = ex_q.mem_read;
    assign ex_MemToReg  = ex_q.mem_to_reg;
    assign ex_Branch    = ex_q.branch;
    assign ex_ALUOp     = ex_q.alu_op;
    assign ex_load_mode = ex_q.load_mode;
    assign ex_pc_plus4  = ex_q.pc_plus4;
    assign ex_rs_data   = ex_q.rs_data;
    assign ex_rt_data   = ex_q.rt_data;
    assign ex_imm       = ex_q.imm;
    assign ex_rs        = ex_q.rs;
    assign ex_rt        = ex_q.rt;
    assign ex_rd        = ex_q.rd;
    assign ex_funct     = ex_q.funct;
    assign ex_write_reg = ex_q.write_reg;
    assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed testbench for id_ex_stage_reg; a second instance with a 3-bit
// counter shares the stimulus so counter saturation is reachable quickly.
module tb_id_ex_stage_reg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, flush, id_valid;
    logic              id_RegDst, id_RegWrite, id_ALUSrc, id_MemWrite;
    logic              id_MemRead, id_MemToReg, id_Branch;
    logic [2:0]        id_ALUOp;
    logic [1:0]        id_load_mode;
    logic [DATA_W-1:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm;
    logic [REG_W-1:0]  id_rs, id_rt, id_rd;
    logic [5:0]        id_funct;

    logic              ex_valid, ex_RegDst, ex_RegWrite, ex_ALUSrc, ex_MemWrite;
    logic              ex_MemRead, ex_MemToReg, ex_Branch;
    logic [2:0]        ex_ALUOp;
    logic [1:0]        ex_load_mode;
    logic [DATA_W-1:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
    logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd, ex_write_reg;
    logic [5:0]        ex_funct;
    logic              hazard_stall;
    logic [CNT_W-1:0]  bubble_count;

    logic              s_valid, s_RegDst, s_RegWrite, s_ALUSrc, s_MemWrite;
    logic              s_MemRead, s_MemToReg, s_Branch;
    logic [2:0]        s_ALUOp;
    logic [1:0]        s_load_mode;
    logic [DATA_W-1:0] s_pc_plus4, s_rs_data, s_rt_data, s_imm;
    logic [REG_W-1:0]  s_rs, s_rt, s_rd, s_write_reg;
    logic [5:0]        s_funct;
    logic              s_stall;
    logic [2:0]        s_count;

    id_ex_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_RegDst(id_RegDst), .id_RegWrite(id_RegWrite), .id_ALUSrc(id_ALUSrc),
        .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead), .id_MemToReg(id_MemToReg),
        .id_Branch(id_Branch), .id_ALUOp(id_ALUOp), .id_load_mode(id_load_mode),
        .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
        .ex_valid(ex_valid), .ex_RegDst(ex_RegDst), .ex_RegWrite(ex_RegWrite),
        .ex_ALUSrc(ex_ALUSrc), .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead),
        .ex_MemToReg(ex_MemToReg), .ex_Branch(ex_Branch), .ex_ALUOp(ex_ALUOp),
        .ex_load_mode(ex_load_mode), .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_write_reg(ex_write_reg),
        .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    id_ex_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_RegDst(id_RegDst), .id_RegWrite(id_RegWrite), .id_ALUSrc(id_ALUSrc),
        .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead), .id_MemToReg(id_MemToReg),
        .id_Branch(id_Branch), .id_ALUOp(id_ALUOp), .id_load_mode(id_load_mode),
        .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
        .ex_valid(s_valid), .ex_RegDst(s_RegDst), .ex_RegWrite(s_RegWrite),
        .ex_ALUSrc(s_ALUSrc), .ex_MemWrite(s_MemWrite), .ex_MemRead(s_MemRead),
        .ex_MemToReg(s_MemToReg), .ex_Branch(s_Branch), .ex_ALUOp(s_ALUOp),
        .ex_load_mode(s_load_mode), .ex_pc_plus4(s_pc_plus4), .ex_rs_data(s_rs_data),
        .ex_rt_data(s_rt_data), .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt),
        .ex_rd(s_rd), .ex_funct(s_funct), .ex_write_reg(s_write_reg),
        .hazard_stall(s_stall), .bubble_count(s_count)
    );

    // {valid,RegDst,RegWrite,ALUSrc,MemWrite,MemRead,MemToReg,Branch,ALUOp,load_mode}
    logic [12:0] ctl_o;
    assign ctl_o = {ex_valid, ex_RegDst, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_MemRead,
                    ex_MemToReg, ex_Branch, ex_ALUOp, ex_load_mode};
    localparam logic [12:0] CTL_BUBBLE = 13'h0040;
    localparam logic [12:0] CTL_ADDI   = 13'h1600;
    localparam logic [12:0] CTL_RTYPE  = 13'h1C08;

    int n_cmp = 0;
    int n_err = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic v, input logic [12:0] c);
        id_valid = v;
        {id_RegDst, id_RegWrite, id_ALUSrc, id_MemWrite, id_MemRead, id_MemToReg,
         id_Branch, id_ALUOp, id_load_mode} = c[11:0];
    endtask

    task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
        set_ctl(1'b1, 13'h1678);
        id_ALUOp = 3'b000; id_load_mode = 2'b00;
        id_RegDst = 1'b0; id_RegWrite = 1'b1; id_ALUSrc = 1'b1; id_MemRead = 1'b1;
        id_MemToReg = 1'b1; id_MemWrite = 1'b0; id_Branch = 1'b0;
        id_rs = rs; id_rt = rt; id_rd = 5'd0; id_imm = 32'd8; id_funct = 6'd0;
        id_pc_plus4 = 32'h40; id_rs_data = 32'h1000; id_rt_data = 32'h0;
    endtask

    task automatic set_addi(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
        set_ctl(1'b1, CTL_ADDI);
        id_rs = rs; id_rt = rt; id_rd = 5'd0; id_imm = imm; id_funct = 6'd0;
        id_pc_plus4 = 32'h100; id_rs_data = 32'h11; id_rt_data = 32'h22;
    endtask

    task automatic set_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        set_ctl(1'b1, CTL_RTYPE);
        id_rs = rs; id_rt = rt; id_rd = rd; id_imm = 32'h0; id_funct = 6'h20;
        id_pc_plus4 = 32'h104; id_rs_data = 32'h33; id_rt_data = 32'h44;
    endtask

    task automatic set_sw(input logic [4:0] rs, input logic [4:0] rt);
        set_ctl(1'b1, 13'h0000);
        id_ALUSrc = 1'b1; id_MemWrite = 1'b1; id_MemToReg = 1'b0;
        id_rs = rs; id_rt = rt; id_rd = 5'd0; id_imm = 32'd4; id_funct = 6'd0;
        id_pc_plus4 = 32'h108; id_rs_data = 32'h55; id_rt_data = 32'h66;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        set_ctl(1'b1, 13'h1FFF);
        id_pc_plus4 = 32'hDEADBEEF; id_rs_data = 32'hA5A5A5A5; id_rt_data = 32'h5A5A5A5A;
        id_imm = 32'hFFFFFFFF; id_rs = 5'd9; id_rt = 5'd10; id_rd = 5'd11; id_funct = 6'h3F;
        step();
        n_cmp++;
        if (ctl_o !== CTL_BUBBLE) begin
            n_err++; $display("FAIL reset_ctl got %h want %h", ctl_o, CTL_BUBBLE);
        end
        n_cmp++;
        if ({ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct,
             ex_write_reg} !== '0) begin
            n_err++; $display("FAIL reset_data got pc=%h imm=%h wr=%h", ex_pc_plus4, ex_imm,
                              ex_write_reg);
        end
        n_cmp++;
        if (bubble_count !== 16'd0 || s_count !== 3'd0) begin
            n_err++; $display("FAIL reset_count got %h/%h want 0", bubble_count, s_count);
        end
        n_cmp++;
        if (hazard_stall !== 1'b0) begin
            n_err++; $display("FAIL reset_stall got %b want 0", hazard_stall);
        end
        rst = 1'b0;
    endtask

    task automatic test_capture();
        set_addi(5'd1, 5'd2, 32'd5);
        #1;
        n_cmp++;
        if (ex_valid !== 1'b0) begin
            n_err++; $display("FAIL capture_no_comb_path got ex_valid=%b want 0", ex_valid);
        end
        step();
        n_cmp++;
        if (ctl_o !== CTL_ADDI || ex_write_reg !== 5'd2 || ex_imm !== 32'd5 ||
            ex_pc_plus4 !== 32'h100 || ex_rs_data !== 32'h11) begin
            n_err++; $display("FAIL capture_addi got ctl=%h wr=%0d imm=%h want ctl=%h wr=2 imm=5",
                              ctl_o, ex_write_reg, ex_imm, CTL_ADDI);
        end
        set_rtype(5'd1, 5'd2, 5'd3);
        #1;
        n_cmp++;
        if (hazard_stall !== 1'b0) begin
            n_err++; $display("FAIL capture_nostall got %b want 0", hazard_stall);
        end
        step();
        n_cmp++;
        if (ctl_o !== CTL_RTYPE || ex_write_reg !== 5'd3 || ex_rd !== 5'd3 ||
            ex_funct !== 6'h20 || ex_rt_data !== 32'h44) begin
            n_err++; $display("FAIL capture_rtype got ctl=%h wr=%0d funct=%h want ctl=%h wr=3",
                              ctl_o, ex_write_reg, ex_funct, CTL_RTYPE);
        end
    endtask

    task automatic test_load_use();
        set_lw(5'd1, 5'd4);
        step();
        set_rtype(5'd4, 5'd5, 5'd6);
        #1;
        n_cmp++;
        if (hazard_stall !== 1'b1) begin
            n_err++; $display("FAIL loaduse_stall got %b want 1", hazard_stall);
        end
        step();
        exp_cnt = exp_cnt + 1;
        n_cmp++;
        if (ctl_o !== CTL_BUBBLE || bubble_count !== exp_cnt) begin
            n_err++; $display("FAIL loaduse_bubble got ctl=%h cnt=%0d want ctl=%h cnt=%0d",
                              ctl_o, bubble_count, CTL_BUBBLE, exp_cnt);
        end
        n_cmp++;
        if (hazard_stall !== 1'b0) begin
            n_err++; $display("FAIL loaduse_selfclear got %b want 0", hazard_stall);
        end
        step();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_write_reg !== 5'd6 || ex_rs !== 5'd4 ||
            bubble_count !== exp_cnt) begin
            n_err++; $display("FAIL loaduse_enter got v=%b wr=%0d rs=%0d cnt=%0d want 1/6/4/%0d",
                              ex_valid, ex_write_reg, ex_rs, bubble_count, exp_cnt);
        end
    endtask

    task automatic test_uses_rt();
        set_lw(5'd1, 5'd4);
        step();
        set_addi(5'd1, 5'd4, 32'd7);
        #1;
        n_cmp++;
        if (hazard_stall !== 1'b0) begin
            n_err++; $display("FAIL usesrt_addi got %b want 0", hazard_stall);
        end
        step();
        set_lw(5'd1, 5'd4);
        step();
        set_sw(5'd1, 5'd4);
        #1;
        n_cmp++;
        if (hazard_stall !== 1'b1) begin
            n_err++; $display("FAIL usesrt_sw got %b want 1", hazard_stall);
        end
        step();
        exp_cnt = exp_cnt + 1;
        n_cmp++;
        if (ex_valid !== 1'b0 || bubble_count !== exp_cnt) begin
            n_err++; $display("FAIL usesrt_sw_bubble got v=%b cnt=%0d want 0/%0d",
                              ex_valid, bubble_count, exp_cnt);
        end
        step();
    endtask

    task automatic test_flush();
        set_lw(5'd1, 5'd4);
        step();
        set_rtype(5'd4, 5'd5, 5'd6);
        flush = 1'b1;
        #1;
        n_cmp++;
        if (hazard_stall !== 1'b0) begin
            n_err++; $display("FAIL flush_stall got %b want 0", hazard_stall);
        end
        step();
        flush = 1'b0;
        n_cmp++;
        if (ctl_o !== CTL_BUBBLE || bubble_count !== exp_cnt) begin
            n_err++; $display("FAIL flush_bubble got ctl=%h cnt=%0d want ctl=%h cnt=%0d",
                              ctl_o, bubble_count, CTL_BUBBLE, exp_cnt);
        end
        set_lw(5'd1, 5'd4);
        step();
        set_rtype(5'd4, 5'd5, 5'd6);
        id_valid = 1'b0;
        #1;
        n_cmp++;
        if (hazard_stall !== 1'b0) begin
            n_err++; $display("FAIL invalid_stall got %b want 0", hazard_stall);
        end
        step();
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_rd !== 5'd6 || ex_write_reg !== 5'd6 ||
            bubble_count !== exp_cnt) begin
            n_err++; $display("FAIL invalid_capture got v=%b rd=%0d wr=%0d cnt=%0d want 0/6/6/%0d",
                              ex_valid, ex_rd, ex_write_reg, bubble_count, exp_cnt);
        end
    endtask

    task automatic test_zero_reg();
        set_lw(5'd1, 5'd0);
        step();
        set_rtype(5'd0, 5'd0, 5'd7);
        #1;
        n_cmp++;
        if (hazard_stall !== 1'b0) begin
            n_err++; $display("FAIL zero_reg_stall got %b want 0", hazard_stall);
        end
        step();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_write_reg !== 5'd7 || bubble_count !== exp_cnt) begin
            n_err++; $display("FAIL zero_reg_enter got v=%b wr=%0d cnt=%0d want 1/7/%0d",
                              ex_valid, ex_write_reg, bubble_count, exp_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 9; i++) begin
            set_lw(5'd2, 5'd7);
            step();
            set_rtype(5'd7, 5'd1, 5'd8);
            step();
            exp_cnt = exp_cnt + 1;
        end
        n_cmp++;
        if (bubble_count !== exp_cnt) begin
            n_err++; $display("FAIL sat_wide got %0d want %0d", bubble_count, exp_cnt);
        end
        n_cmp++;
        if (s_count !== 3'h7) begin
            n_err++; $display("FAIL sat_narrow got %h want 7", s_count);
        end
        set_lw(5'd2, 5'd7);
        step();
        set_rtype(5'd7, 5'd1, 5'd8);
        #1;
        n_cmp++;
        if (s_stall !== 1'b1) begin
            n_err++; $display("FAIL sat_narrow_stall got %b want 1", s_stall);
        end
        step();
        exp_cnt = exp_cnt + 1;
        n_cmp++;
        if (s_count !== 3'h7 || bubble_count !== exp_cnt) begin
            n_err++; $display("FAIL sat_hold got %h/%0d want 7/%0d", s_count, bubble_count, exp_cnt);
        end
    endtask

    task automatic test_reset_midstall();
        set_lw(5'd1, 5'd4);
        step();
        set_rtype(5'd4, 5'd5, 5'd6);
        #1;
        n_cmp++;
        if (hazard_stall !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_pre got %b want 1", hazard_stall);
        end
        rst = 1'b1;
        step();
        exp_cnt = '0;
        n_cmp++;
        if (ctl_o !== CTL_BUBBLE || bubble_count !== exp_cnt || hazard_stall !== 1'b0) begin
            n_err++; $display("FAIL rst_mid got ctl=%h cnt=%0d stall=%b want %h/0/0",
                              ctl_o, bubble_count, hazard_stall, CTL_BUBBLE);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_load_use();
        test_uses_rt();
        test_flush();
        test_zero_reg();
        test_saturation();
        test_reset_midstall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
